// File: rtl/cbx_cfg_shadow.sv
// cbx_cfg_shadow: X-channel connection block with a double-buffered (shadow/active) config chain.
// Latency: channel pass-through and ipin are combinational; ccff_tail trails ccff_head by TOTAL shifts.
// Backpressure: none; shifting never disturbs routing, only a verified commit updates the active selects.
//
// Ports:
//   prog_clk, prog_reset       configuration clock, async active-high reset
//   chanx_left_in/right_in     horizontal channel tracks entering the block
//   chanx_left_out/right_out   straight pass-through of the opposite side
//   ccff_head, ccff_en         serial config data in and shift enable
//   ccff_tail                  serial config data out (last shadow bit), to the next block
//   cfg_commit                 strobe: copy shadow to active if exactly TOTAL bits were loaded
//   ipin                       grid input pins driven by the per-pin muxes
//   cfg_full                   counter sits at exactly TOTAL bits
//   cfg_err                    sticky: a commit was attempted with a short or overfull load

module cbx_cfg_shadow #(
   parameter int CHAN_W     = 20,
   parameter int NUM_IPIN   = 8,
   parameter int MUX_SIZE   = 10,
   parameter int TRACK_STEP = 2
) (
   input  logic                prog_clk,
   input  logic                prog_reset,
   input  logic [CHAN_W-1:0]   chanx_left_in,
   input  logic [CHAN_W-1:0]   chanx_right_in,
   output logic [CHAN_W-1:0]   chanx_left_out,
   output logic [CHAN_W-1:0]   chanx_right_out,
   input  logic                ccff_head,
   input  logic                ccff_en,
   input  logic                cfg_commit,
   output logic                ccff_tail,
   output logic [NUM_IPIN-1:0] ipin,
   output logic                cfg_full,
   output logic                cfg_err
);

   localparam int SEL_W   = $clog2(MUX_SIZE);
   localparam int TOTAL   = NUM_IPIN * SEL_W;
   localparam int CNT_W   = $clog2(TOTAL + 2);
   // Mux input vector is padded to a power of two; the pad slots are tied low so
   // an out-of-range select drives 0 without a separate range compare.
   localparam int MUX_PAD = 1 << SEL_W;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);
   localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(TOTAL + 1);

   logic [TOTAL-1:0] shadow;
   logic [TOTAL-1:0] active;
   logic [CNT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             full_q;
   logic             err_q;
   logic             commit_ok;

   // ------------------------------------------------------------------
   // Channel pass-through
   // ------------------------------------------------------------------
   assign chanx_left_out  = chanx_right_in;
   assign chanx_right_out = chanx_left_in;

   // ------------------------------------------------------------------
   // Bit counter next state. A commit always restarts the count; if a shift
   // lands on the same edge, that shifted bit is the first of the next load.
   // ------------------------------------------------------------------
   assign commit_ok = (bit_cnt == CNT_FULL);

   always_comb begin
      cnt_nxt = bit_cnt;
      if (cfg_commit) begin
         cnt_nxt = ccff_en ? CNT_W'(1) : '0;
      end else if (ccff_en && (bit_cnt != CNT_OVER)) begin
         cnt_nxt = bit_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Shadow chain, active selects and status flags
   // ------------------------------------------------------------------
   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         shadow  <= '0;
         active  <= '0;
         bit_cnt <= '0;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         // shadow[0] takes the head bit, every other bit moves up one index
         if (ccff_en) begin
            shadow <= {shadow[TOTAL-2:0], ccff_head};
         end
         // Commit decision and the copy both use the pre-edge shadow/counter
         if (cfg_commit) begin
            if (commit_ok) begin
               active <= shadow;
               err_q  <= 1'b0;
            end else begin
               err_q  <= 1'b1;
            end
         end
         bit_cnt <= cnt_nxt;
         full_q  <= (cnt_nxt == CNT_FULL);
      end
   end

   assign ccff_tail = shadow[TOTAL-1];
   assign cfg_full  = full_q;
   assign cfg_err   = err_q;

   // ------------------------------------------------------------------
   // Per-pin routing muxes. Input k of pin p: even k from the left side,
   // odd k from the right side, track (p + (k/2)*TRACK_STEP) mod CHAN_W.
   // ------------------------------------------------------------------
   for (genvar p = 0; p < NUM_IPIN; p++) begin : g_pin
      logic [MUX_PAD-1:0] mux_in;
      logic [SEL_W-1:0]   sel;

      assign sel = active[p*SEL_W +: SEL_W];

      for (genvar k = 0; k < MUX_PAD; k++) begin : g_in
         localparam int TRK = (p + (k / 2) * TRACK_STEP) % CHAN_W;
         if (k >= MUX_SIZE) begin : g_pad
            assign mux_in[k] = 1'b0;
         end else if ((k % 2) == 0) begin : g_left
            assign mux_in[k] = chanx_left_in[TRK];
         end else begin : g_right
            assign mux_in[k] = chanx_right_in[TRK];
         end
      end

      assign ipin[p] = mux_in[sel];
   end

endmodule

// File: tb/tb_cbx_cfg_shadow.sv
// tb_cbx_cfg_shadow: directed and randomized checks of cbx_cfg_shadow against a queue/array reference model.
// Latency: one check per configuration cycle, sampled 2 time units after the rising edge.
// Backpressure: not applicable; the bench drives every input directly.

module tb_cbx_cfg_shadow;

   localparam int CHAN_W     = 20;
   localparam int NUM_IPIN   = 8;
   localparam int MUX_SIZE   = 10;
   localparam int TRACK_STEP = 2;
   localparam int SEL_W      = 4;
   localparam int TOTAL      = 32;

   logic                prog_clk = 1'b0;
   logic                prog_reset;
   logic [CHAN_W-1:0]   chanx_left_in;
   logic [CHAN_W-1:0]   chanx_right_in;
   logic [CHAN_W-1:0]   chanx_left_out;
   logic [CHAN_W-1:0]   chanx_right_out;
   logic                ccff_head;
   logic                ccff_en;
   logic                cfg_commit;
   logic                ccff_tail;
   logic [NUM_IPIN-1:0] ipin;
   logic                cfg_full;
   logic                cfg_err;

   cbx_cfg_shadow #(
      .CHAN_W     (CHAN_W),
      .NUM_IPIN   (NUM_IPIN),
      .MUX_SIZE   (MUX_SIZE),
      .TRACK_STEP (TRACK_STEP)
   ) dut (
      .prog_clk        (prog_clk),
      .prog_reset      (prog_reset),
      .chanx_left_in   (chanx_left_in),
      .chanx_right_in  (chanx_right_in),
      .chanx_left_out  (chanx_left_out),
      .chanx_right_out (chanx_right_out),
      .ccff_head       (ccff_head),
      .ccff_en         (ccff_en),
      .cfg_commit      (cfg_commit),
      .ccff_tail       (ccff_tail),
      .ipin            (ipin),
      .cfg_full        (cfg_full),
      .cfg_err         (cfg_err)
   );

   always #5 prog_clk = ~prog_clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: the last TOTAL shifted bits (newest at the back), a
   // plain integer load count, decoded per-pin select values and the error flag.
   bit hist[$];
   int cnt_m;
   int sel_m [NUM_IPIN];
   bit err_m;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Value of shadow[i]: bit shifted in i shifts ago
   function automatic bit sh_bit(input int i);
      if (hist.size() > i) return hist[hist.size() - 1 - i];
      return 1'b0;
   endfunction

   function automatic logic [NUM_IPIN-1:0] exp_ipin();
      logic [NUM_IPIN-1:0] r;
      r = '0;
      for (int p = 0; p < NUM_IPIN; p++) begin
         int s, trk;
         s = sel_m[p];
         if (s < MUX_SIZE) begin
            trk = (p + (s / 2) * TRACK_STEP) % CHAN_W;
            r[p] = (s % 2 == 0) ? chanx_left_in[trk] : chanx_right_in[trk];
         end
      end
      return r;
   endfunction

   task automatic model_reset();
      hist.delete();
      cnt_m = 0;
      err_m = 1'b0;
      for (int p = 0; p < NUM_IPIN; p++) sel_m[p] = 0;
   endtask

   task automatic model_edge(input bit en, input bit head, input bit commit);
      if (commit) begin
         if (cnt_m == TOTAL) begin
            for (int p = 0; p < NUM_IPIN; p++) begin
               int s;
               s = 0;
               for (int j = 0; j < SEL_W; j++) s += int'(sh_bit(p * SEL_W + j)) << j;
               sel_m[p] = s;
            end
            err_m = 1'b0;
         end else begin
            err_m = 1'b1;
         end
         cnt_m = 0;
      end
      if (en) begin
         hist.push_back(head);
         if (hist.size() > TOTAL) void'(hist.pop_front());
         if (cnt_m < TOTAL + 1) cnt_m++;
      end
   endtask

   task automatic rand_chan();
      chanx_left_in  = CHAN_W'($urandom);
      chanx_right_in = CHAN_W'($urandom);
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ":ipin"},      64'(ipin),            64'(exp_ipin()));
      chk({tag, ":tail"},      64'(ccff_tail),       64'(sh_bit(TOTAL - 1)));
      chk({tag, ":full"},      64'(cfg_full),        64'(cnt_m == TOTAL));
      chk({tag, ":err"},       64'(cfg_err),         64'(err_m));
      chk({tag, ":left_out"},  64'(chanx_left_out),  64'(chanx_right_in));
      chk({tag, ":right_out"}, 64'(chanx_right_out), 64'(chanx_left_in));
   endtask

   task automatic tick(input bit en, input bit head, input bit commit, input string tag);
      ccff_en    = en;
      ccff_head  = head;
      cfg_commit = commit;
      @(posedge prog_clk);
      model_edge(en, head, commit);
      #1;
      ccff_en    = 1'b0;
      cfg_commit = 1'b0;
      rand_chan();
      #1;
      check_outputs(tag);
   endtask

   // Shift nbits, MSB of the target word first so word bit i ends in shadow[i]
   task automatic load(input logic [TOTAL-1:0] w, input int nbits, input string tag);
      for (int n = 0; n < nbits; n++) begin
         tick(1'b1, (n < TOTAL) ? w[TOTAL - 1 - n] : 1'b0, 1'b0, tag);
      end
   endtask

   logic [63:0] pat;

   initial begin
      prog_reset     = 1'b1;
      ccff_head      = 1'b0;
      ccff_en        = 1'b0;
      cfg_commit     = 1'b0;
      chanx_left_in  = '0;
      chanx_right_in = '0;
      model_reset();

      // Reset state with random channel traffic
      for (int i = 0; i < 4; i++) begin
         rand_chan();
         #3;
         check_outputs("reset");
         chk("reset:ipin_left", 64'(ipin), 64'(chanx_left_in[NUM_IPIN-1:0]));
      end
      @(negedge prog_clk);
      prog_reset = 1'b0;

      // Full load: pin 0 sel=3, others sel=0
      load(32'h0000_0003, TOTAL, "full_load");
      chk("full_load:cfg_full", 64'(cfg_full), 64'd1);
      chk("full_load:ipin0_old", 64'(ipin[0]), 64'(chanx_left_in[0]));
      tick(1'b0, 1'b0, 1'b1, "full_commit");
      chk("full_commit:ipin0_r2", 64'(ipin[0]), 64'(chanx_right_in[2]));
      chk("full_commit:cfg_full", 64'(cfg_full), 64'd0);

      // Short load then commit: error, routing unchanged
      load(32'hA5A5_5A5A, TOTAL - 1, "short_load");
      tick(1'b0, 1'b0, 1'b1, "short_commit");
      chk("short_commit:cfg_err", 64'(cfg_err), 64'd1);
      chk("short_commit:ipin0_r2", 64'(ipin[0]), 64'(chanx_right_in[2]));
      load(32'h1234_5678, TOTAL, "recover_load");
      tick(1'b0, 1'b0, 1'b1, "recover_commit");
      chk("recover_commit:cfg_err", 64'(cfg_err), 64'd0);

      // Overfull load, then out-of-range select on pin 5
      load(32'h0000_0003, TOTAL + 1, "over_load");
      tick(1'b0, 1'b0, 1'b1, "over_commit");
      chk("over_commit:cfg_err", 64'(cfg_err), 64'd1);
      load(32'h00C0_0000, TOTAL, "oor_load");
      tick(1'b0, 1'b0, 1'b1, "oor_commit");
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b0, 1'b0, "oor_hold");
         chk("oor_hold:ipin5_zero", 64'(ipin[5]), 64'd0);
      end
      chk("oor_commit:cfg_err", 64'(cfg_err), 64'd0);

      // Chain pass-through: tail replays the pattern TOTAL shifts later
      pat = {$urandom, $urandom};
      for (int n = 0; n < 64; n++) begin
         tick(1'b1, pat[n], 1'b0, "chain");
         if (n + 1 >= TOTAL) chk("chain:tail_delay", 64'(ccff_tail), 64'(pat[n + 1 - TOTAL]));
      end

      // Simultaneous shift and commit with counter at TOTAL
      tick(1'b0, 1'b0, 1'b1, "pre_sim_commit");
      load(32'h0000_0003, TOTAL, "sim_load");
      tick(1'b1, 1'b1, 1'b1, "sim_commit");
      chk("sim_commit:ipin0_r2", 64'(ipin[0]), 64'(chanx_right_in[2]));
      chk("sim_commit:cfg_full", 64'(cfg_full), 64'd0);
      chk("sim_commit:cfg_err", 64'(cfg_err), 64'd0);
      load(32'hFFFF_FFFF, TOTAL - 1, "sim_after");
      chk("sim_after:cfg_full", 64'(cfg_full), 64'd1);

      // Held commit: second cycle sees counter 0 and flags an error
      tick(1'b0, 1'b0, 1'b1, "held_commit1");
      tick(1'b0, 1'b0, 1'b1, "held_commit2");
      chk("held_commit2:cfg_err", 64'(cfg_err), 64'd1);

      // Async reset mid-load
      load(32'hDEAD_BEEF, 10, "pre_rst_load");
      prog_reset = 1'b1;
      #1;
      model_reset();
      check_outputs("async_rst");
      chk("async_rst:ipin_left", 64'(ipin), 64'(chanx_left_in[NUM_IPIN-1:0]));
      chk("async_rst:tail", 64'(ccff_tail), 64'd0);
      @(negedge prog_clk);
      prog_reset = 1'b0;

      // Randomized traffic
      for (int r = 0; r < 60; r++) begin
         if ($urandom_range(0, 1) == 0) begin
            load(TOTAL'($urandom), TOTAL, "rnd_load");
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick(1'b0, 1'b0, 1'b0, "rnd_idle");
            tick(1'($urandom_range(0, 1)), 1'($urandom), 1'b1, "rnd_commit");
         end else begin
            for (int c = 0; c < 20; c++) begin
               tick(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 19) == 0), "rnd_mix");
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
